// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory request, output register
// plus one-entry skid buffer, redirect flush with drain of in-flight reads.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [15:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [15:0] fetch_cnt_q, fetch_cnt_d;

    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target    = redirect_pc & ~32'h3;
    assign pc_inc    = fetch_pc_q + 32'd4;
    assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr = fetch_pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign fetch_cnt = fetch_cnt_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        redir_pc_d   = redir_pc_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        fetch_cnt_d  = fetch_cnt_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect) begin
                    fetch_pc_d   = target;
                    if_valid_d   = 1'b0;
                    skid_valid_d = 1'b0;
                end
            end
            FETCH: begin
                if (redirect) begin
                    if_valid_d   = 1'b0;
                    skid_valid_d = 1'b0;
                    if (imem_ack) begin
                        fetch_pc_d = target;
                    end else begin
                        // Read still in flight: wait for it before refetching.
                        redir_pc_d = target;
                        state_d    = DRAIN;
                    end
                end else if (imem_ack) begin
                    fetch_pc_d = pc_inc;
                    if (!stall || !if_valid_q) begin
                        if_instr_d  = imem_rdata;
                        if_pc_d     = fetch_pc_q;
                        if_valid_d  = 1'b1;
                        fetch_cnt_d = fetch_cnt_q + 16'd1;
                    end else begin
                        skid_valid_d = 1'b1;
                        skid_pc_d    = fetch_pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    if_valid_d   = 1'b0;
                    skid_valid_d = 1'b0;
                    fetch_pc_d   = target;
                    state_d      = FETCH;
                end else if (!stall) begin
                    if_instr_d   = skid_instr_q;
                    if_pc_d      = skid_pc_q;
                    if_valid_d   = 1'b1;
                    skid_valid_d = 1'b0;
                    fetch_cnt_d  = fetch_cnt_q + 16'd1;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                if_valid_d   = 1'b0;
                skid_valid_d = 1'b0;
                if (imem_ack) begin
                    fetch_pc_d = redirect ? target : redir_pc_q;
                    state_d    = FETCH;
                end else if (redirect) begin
                    redir_pc_d = target;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            redir_pc_q   <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'h0;
            if_instr_q   <= 32'h0;
            fetch_cnt_q  <= 16'h0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            redir_pc_q   <= redir_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, compared
// every cycle against a queue-based model of the fetch pipeline.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [15:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .fetch_cnt  (fetch_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: pipeline = output slot + skid queue; a request is open whenever
    // the unit is running and the skid is empty; a flushed read is "discarded".
    logic        m_idle;
    logic [31:0] m_pc;
    logic        m_disc;
    logic [31:0] m_dtgt;
    logic        m_ov;
    logic [31:0] m_opc;
    logic [31:0] m_oinstr;
    logic [15:0] m_cnt;
    logic [63:0] skidq[$];

    function automatic logic m_req();
        return !m_idle && (skidq.size() == 0);
    endfunction

    task automatic model(input logic r, input logic s, input logic rd,
                         input logic [31:0] rp, input logic a,
                         input logic [31:0] rdat);
        logic        req;
        logic [31:0] tgt;
        logic [63:0] w;
        req = m_req();
        tgt = rp & ~32'h3;
        if (r) begin
            m_idle = 1'b1; m_pc = RESET_PC; m_disc = 1'b0; m_dtgt = 32'h0;
            m_ov = 1'b0; m_opc = 32'h0; m_oinstr = 32'h0; m_cnt = 16'h0;
            skidq.delete();
            return;
        end
        if (rd) begin
            m_ov = 1'b0;
            skidq.delete();
            if (req && !a) begin
                m_disc = 1'b1;
                m_dtgt = tgt;
            end else begin
                m_pc   = tgt;
                m_disc = 1'b0;
            end
        end else if (skidq.size() != 0) begin
            if (!s) begin
                w = skidq.pop_front();
                m_opc = w[63:32]; m_oinstr = w[31:0];
                m_ov = 1'b1; m_cnt = m_cnt + 16'd1;
            end
        end else if (req && a) begin
            if (m_disc) begin
                m_pc = m_dtgt; m_disc = 1'b0;
            end else if (!s || !m_ov) begin
                m_opc = m_pc; m_oinstr = rdat; m_ov = 1'b1;
                m_cnt = m_cnt + 16'd1; m_pc = m_pc + 32'd4;
            end else begin
                skidq.push_back({m_pc, rdat});
                m_pc = m_pc + 32'd4;
            end
        end else if (!s) begin
            m_ov = 1'b0;
        end
        m_idle = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
        if (m_req()) chk("imem_addr", imem_addr, m_pc);
        chk("if_valid", {31'h0, if_valid}, {31'h0, m_ov});
        chk("if_pc", if_pc, m_opc);
        chk("if_instr", if_instr, m_oinstr);
        chk("fetch_cnt", {16'h0, fetch_cnt}, {16'h0, m_cnt});
    endtask

    task automatic step(input logic r, input logic s, input logic rd,
                        input logic [31:0] rp, input logic a);
        logic [31:0] rdat;
        rdat = $urandom;
        rst = r; stall = s; redirect = rd; redirect_pc = rp;
        imem_ack = a; imem_rdata = rdat;
        @(posedge clk);
        model(r, s, rd, rp, a, rdat);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bit done;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;

        // Reset, then streaming fetch
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("first_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        chk("cnt3", {16'h0, fetch_cnt}, 32'd3);
        chk("pc_lag", if_pc, RESET_PC + 32'd8);

        // Stall three cycles with ack offered each cycle
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

        // Redirect with same-cycle ack
        step(0, 0, 1, 32'h0000_0103, 1);
        chk("redir_addr", imem_addr, 32'h0000_0100);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1);

        // Redirect while the read is delayed
        step(0, 0, 1, 32'h0000_0040, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("drain_addr", imem_addr, 32'h0000_0040);
        step(0, 0, 0, 0, 1);

        // Address wrap and counter wrap
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, 1);
        chk("pc_wrap", imem_addr, 32'h0);
        done = 1'b0;
        for (int i = 0; i < 70000 && !done; i++) begin
            if (m_cnt == 16'hFFFF) done = 1'b1;
            else step(0, 0, 0, 0, 1);
        end
        chk("cnt_ffff", {16'h0, fetch_cnt}, 32'h0000_FFFF);
        step(0, 0, 0, 0, 1);
        chk("cnt_wrap", {16'h0, fetch_cnt}, 32'h0);

        // Reset during DRAIN with a same-cycle ack
        step(0, 0, 1, 32'h0000_0800, 0);
        step(1, 0, 0, 0, 1);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_cnt", {16'h0, fetch_cnt}, 32'h0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("rst_addr", imem_addr, RESET_PC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom,
                 ($urandom_range(0, 1) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 imem_req  out  1  instruction-memory request; held high until imem_ack.
REQ-005 imem_addr  out  32  word-aligned fetch address; stable while imem_req high and no ack.
REQ-006 imem_ack  in  1  read done; imem_rdata valid this cycle; same-cycle ack allowed.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 stall  in  1  downstream cannot accept; output registers hold.
REQ-009 redirect  in  1  branch/jump taken; flush and refetch from redirect_pc.
REQ-010 redirect_pc  in  32  next-PC from branch stage; bits [1:0] forced to 0 on capture.
REQ-011 if_valid  out  1  if_pc/if_instr hold a live instruction.
REQ-012 if_pc  out  32  address of if_instr (branch-stage pc_in).
REQ-013 if_instr  out  32  instruction word (branch-stage instru).
REQ-014 fetch_cnt  out  16  count of instructions delivered to if_* outputs.

Function
REQ-015 States: IDLE, FETCH, HOLD, DRAIN; encoding free, not exported.
REQ-016 IDLE: imem_req=0; unconditional move to FETCH next cycle.
REQ-017 FETCH: imem_req=1, imem_addr=fetch_pc.
REQ-018 FETCH, imem_ack, no redirect: fetch_pc<=fetch_pc+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 FETCH, ack, no redirect, (stall=0 or if_valid=0): if_instr<=imem_rdata, if_pc<=fetch_pc, if_valid<=1, fetch_cnt+1; stay FETCH.
REQ-020 FETCH, ack, no redirect, stall=1 and if_valid=1: word+address into one-entry skid buffer; go HOLD; if_* unchanged.
REQ-021 FETCH, no ack, stall=0: if_valid<=0 (current output consumed, no replacement).
REQ-022 HOLD: imem_req=0; when stall=0, skid contents to if_*, if_valid<=1, fetch_cnt+1, go FETCH.
REQ-023 Any state, stall=1 and if_valid=1 and no redirect: if_valid, if_pc, if_instr unchanged.
REQ-024 Redirect beats stall and ack; redirect cycle: if_valid<=0, skid cleared, fetch_cnt unchanged.
REQ-025 Redirect in FETCH with imem_ack=1 or in HOLD: returned word dropped, fetch_pc<=redirect_pc&~3, go FETCH.
REQ-026 Redirect in FETCH, imem_ack=0: target into redir_pc, go DRAIN; imem_addr keeps old address.
REQ-027 DRAIN: imem_req=1 at old address; further redirect overwrites redir_pc (latest wins).
REQ-028 DRAIN, imem_ack: data dropped, fetch_pc<=redir_pc, go FETCH; if_valid stays 0.
REQ-029 fetch_cnt wraps 16'hFFFF to 0; counts only words loaded into if_*.
REQ-030 Never more than one outstanding memory request; never more than two instructions buffered (output + skid).

Reset
REQ-031 rst=1 at a rising edge: state<=IDLE, fetch_pc<=RESET_PC, redir_pc<=0, skid empty, if_valid<=0, if_pc<=0, if_instr<=0, fetch_cnt<=0.
REQ-032 imem_req=0 while state=IDLE, including the reset cycle.
REQ-033 Reset mid-transaction (FETCH/DRAIN) abandons the request; a late imem_ack in IDLE is ignored.
REQ-034 Reset beats redirect, stall and ack in the same cycle.

Verification
REQ-035 Reset release, ack each cycle, stall=0 -> imem_addr 0,4,8,...; if_pc one cycle behind; fetch_cnt 1,2,3.
REQ-036 Stall held 3 cycles, ack each cycle -> if_pc frozen; one word in skid; imem_req=0 in HOLD; no word lost or duplicated after release.
REQ-037 Redirect to 32'h0000_0103 with ack=1 -> if_valid 0 next cycle; next imem_addr 32'h0000_0100; dropped word not counted.
REQ-038 Redirect to 32'h40 while ack delayed 2 cycles -> DRAIN keeps old imem_addr until ack; next request 32'h40; if_valid 0 throughout.
REQ-039 fetch_pc 32'hFFFF_FFFC, ack -> next imem_addr 0; fetch_cnt 16'hFFFF then 0 on next delivery.
REQ-040 rst=1 during DRAIN with ack arriving the same cycle -> all outputs at reset values; first request after release at RESET_PC.
